fpga_dbg_uart_tx: RTL and testbench
===================================

Name: fpga_dbg_uart_tx

Overview:
- Byte-oriented debug UART transmitter on the Nexys FPGA top.
- Runs directly upstream of the dbg_uart_tx board pin, next to the PULPissimo instance.
- Accepts status/trace bytes over a valid/ready interface, buffers them in a small FIFO and serialises them as 8N1 frames (8E1 with the optional feature).
- Lets the SoC and FPGA glue logic emit debug text without loading the SoC's own UART.

Parameters:
CLK_FREQ_HZ, 10000000, frequency of clk_i in Hz
BAUD_RATE, 115200, line rate in bit/s; bit period DIV = CLK_FREQ_HZ/BAUD_RATE (integer division, truncated); elaboration error if DIV < 2
FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2

Ports:
clk_i  in  1  single clock, all logic rising-edge
rst_i  in  1  synchronous, active-high reset
data_i  in  8  byte to transmit
valid_i  in  1  data_i valid
ready_o  out  1  FIFO can accept; transfer on valid_i && ready_o at a rising edge
flush_i  in  1  drop all FIFO contents; does not abort a frame in flight
tx_o  out  1  serial line, idle high, registered output
busy_o  out  1  FSM not IDLE or FIFO non-empty
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO entries held; excludes the byte in the shift register

Behaviour:
- Reset (rst_i high at an edge), values from the following cycle:
  - tx_o=1, ready_o=0 while rst_i is held, busy_o=0, fifo_level_o=0.
  - FSM=IDLE; baud counter, bit counter and FIFO pointers cleared.
  - ready_o=1 in the first cycle after rst_i deasserts.
- Reset mid-frame: frame aborted, tx_o=1 from the next cycle, buffered bytes discarded; no truncated-frame recovery.
- FIFO:
  - ready_o = !full.
  - Push on valid_i && ready_o.
  - Pop only when the FSM is in IDLE, or in STOP on its last cycle, and the FIFO is non-empty.
  - Push and pop in the same cycle: level unchanged.
  - Full: ready_o=0; a pop in cycle N raises ready_o in cycle N+1, with no combinational ready path from the pop.
  - Pointers wrap modulo FIFO_DEPTH; the extra level bit distinguishes full from empty.
- flush_i: level -> 0 at that edge; a simultaneous push is discarded. The shift register and current frame are unaffected.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE -> START on pop: byte loaded into the shift register, tx_o=0 from the pop edge.
  - START: DIV cycles at 0 -> DATA.
  - DATA: 8 bits LSB first, DIV cycles each; bit counter 0..7 -> STOP (or PARITY).
  - STOP: DIV cycles at 1. On its last cycle, pop if the FIFO is non-empty and go straight to START (back-to-back, no idle gap); otherwise -> IDLE.
- Baud counter: counts 0..DIV-1 and restarts at 0 on every state change. Every bit lasts exactly DIV cycles; the frame is 10*DIV cycles (11*DIV with parity).
- Latency: a byte accepted at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1, so tx_o falls at E+1.
- busy_o and fifo_level_o are registered and consistent with the FIFO state after each edge.

Optional Feature:
- Macro: DBG_UART_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Drives even parity (XOR of the 8 data bits) for DIV cycles.
  - Frame is 11*DIV cycles.
- Undefined:
  - No PARITY state or logic.
  - Frame is 10*DIV cycles, 8N1.

Test Plan:
- CLK_FREQ_HZ=8, BAUD_RATE=2 (DIV=4). Push 0x55 after reset -> tx_o low from E+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy_o falls at E+41.
- Push 0xA3 and 0x0F on consecutive cycles -> second start bit begins exactly 40 cycles after the first; tx_o never high between the frames apart from the stop bit; fifo_level_o sequence 1,1,0.
- FIFO_DEPTH=4, hold valid_i for 8 cycles -> 5 bytes accepted (1 to the shift register, 4 in the FIFO); ready_o low until the next pop; all 5 bytes appear on tx_o in order; no byte lost or duplicated.
- Assert rst_i during DATA bit 3 of 0xFF with 3 bytes queued -> tx_o=1, fifo_level_o=0, busy_o=0 from the next cycle; stays idle after release.
- flush_i with 2 bytes queued during the frame of 0x41 -> 0x41 completes intact, fifo_level_o=0, no further frames.
- DBG_UART_PARITY_EN defined, push 0x07 -> parity bit 1 after data; frame 44 cycles. Push 0x03 -> parity bit 0.

Source files
------------

// File: rtl/fpga_dbg_uart_tx.sv
// fpga_dbg_uart_tx
//   Byte-oriented debug UART transmitter for the Nexys FPGA top. Bytes are
//   accepted over a valid/ready handshake, buffered in a small FIFO and sent
//   on tx_o as 8N1 frames. Frames go back-to-back while the FIFO has data.
//
//   Optional feature macro: DBG_UART_PARITY_EN
//     defined   : 8E1 frames (even parity bit between data and stop bits)
//     undefined : 8N1 frames
//
// Parameters
//   CLK_FREQ_HZ  clk_i frequency in Hz
//   BAUD_RATE    line rate; bit period DIV = CLK_FREQ_HZ / BAUD_RATE (>= 2)
//   FIFO_DEPTH   byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous active-high reset
//   data_i        byte to transmit
//   valid_i       data_i valid
//   ready_o       FIFO can accept (registered, low while in reset)
//   flush_i       drop all FIFO contents; the frame in flight completes
//   tx_o          serial line, idle high, registered
//   busy_o        frame in progress or FIFO non-empty (registered)
//   fifo_level_o  bytes held in the FIFO, excluding the shift register
module fpga_dbg_uart_tx #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic                          flush_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = $clog2((DIV < 2) ? 2 : DIV);

  if (DIV < 2) begin : g_bad_div
    $error("fpga_dbg_uart_tx: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fpga_dbg_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

`ifdef DBG_UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_n;
  logic          ready_r;
  logic          busy_r;
  logic          push;
  logic          pop;
  logic          can_pop;
  logic [7:0]    rd_data;

  // Transmit FSM
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          tx_r;
  logic          tx_n;
  logic          bit_last;
`ifdef DBG_UART_PARITY_EN
  logic          par_r;
  logic          par_n;
`endif

  assign ready_o      = ready_r;
  assign busy_o       = busy_r;
  assign tx_o         = tx_r;
  assign fifo_level_o = level;

  assign rd_data  = mem[rd_ptr];
  assign push     = valid_i && ready_r && !flush_i;
  // A flush empties the FIFO at this edge, so nothing may be taken from it.
  assign can_pop  = (level != '0) && !flush_i;
  assign bit_last = (cnt == CW'(DIV - 1));

  // ---------------------------------------------------------------------
  // Next-state / output logic. tx_n is the line value for the state being
  // entered so that tx_o can be a plain register with no output glitches.
  // ---------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = tx_r;
    pop       = 1'b0;
`ifdef DBG_UART_PARITY_EN
    par_n     = par_r;
`endif

    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (can_pop) begin
          pop     = 1'b1;
          state_n = S_START;
          shreg_n = rd_data;
          tx_n    = 1'b0;
`ifdef DBG_UART_PARITY_EN
          par_n   = ^rd_data;
`endif
        end
      end

      S_START: begin
        tx_n = 1'b0;
        if (bit_last) begin
          state_n   = S_DATA;
          cnt_n     = '0;
          bit_cnt_n = '0;
          tx_n      = shreg[0];
        end
      end

      S_DATA: begin
        tx_n = shreg[0];
        if (bit_last) begin
          cnt_n = '0;
          if (bit_cnt == 3'd7) begin
`ifdef DBG_UART_PARITY_EN
            state_n = S_PARITY;
            tx_n    = par_r;
`else
            state_n = S_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end
      end

`ifdef DBG_UART_PARITY_EN
      S_PARITY: begin
        tx_n = par_r;
        if (bit_last) begin
          state_n = S_STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        tx_n = 1'b1;
        if (bit_last) begin
          cnt_n = '0;
          // Back-to-back: the next start bit follows the stop bit directly.
          if (can_pop) begin
            pop     = 1'b1;
            state_n = S_START;
            shreg_n = rd_data;
            tx_n    = 1'b0;
`ifdef DBG_UART_PARITY_EN
            par_n   = ^rd_data;
`endif
          end else begin
            state_n = S_IDLE;
          end
        end
      end

      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  // FIFO level after this edge; registered ready/busy are derived from it so
  // a pop frees a slot on ready_o one cycle later with no combinational path.
  always_comb begin
    level_n = level;
    if (flush_i) begin
      level_n = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_n = level + LW'(1);
        2'b01:   level_n = level - LW'(1);
        default: level_n = level;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_r    <= 1'b1;
`ifdef DBG_UART_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      tx_r    <= tx_n;
`ifdef DBG_UART_PARITY_EN
      par_r   <= par_n;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      level   <= level_n;
      ready_r <= (level_n != LW'(FIFO_DEPTH));
      busy_r  <= (state_n != S_IDLE) || (level_n != '0);
    end
  end

  // Storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: tb/tb_fpga_dbg_uart_tx.sv
module tb_fpga_dbg_uart_tx;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef DBG_UART_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam int FC = FL * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       flush = 1'b0;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;

  fpga_dbg_uart_tx #(
    .CLK_FREQ_HZ(8),
    .BAUD_RATE  (2),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data),
    .valid_i     (valid),
    .ready_o     (ready),
    .flush_i     (flush),
    .tx_o        (tx),
    .busy_o      (busy),
    .fifo_level_o(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line value at frame bit index idx: start, 8 data LSB first, [parity], stop.
  function automatic int frame_bit(input logic [7:0] b, input logic par, input int idx);
    if (idx == 0) return 0;
    if (idx <= 8) return int'(b[idx-1]);
`ifdef DBG_UART_PARITY_EN
    if (idx == 9) return int'(par);
`endif
    return 1;
  endfunction

  initial begin
    vec_t vecs[7];
    logic [7:0] fill_q[$];
    logic [7:0] mq[$];
    logic [7:0] b2[2];
    logic [7:0] cur;
    logic       active;
    int         pos;
    int         accepted;
    logic       mpush;
    int         pre;
    logic       end_now;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA3, 1'b0};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h07, 1'b1};
    vecs[5] = '{8'h03, 1'b0};
    vecs[6] = '{8'h80, 1'b1};

    // ---- reset state ----
    rst = 1'b1;
    tick(); tick();
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", ready, 1);
    check("post_rst_tx", tx, 1);
    tick();

    // ---- table-driven single frames ----
    for (int i = 0; i < 7; i++) begin
      data = vecs[i].data;
      valid = 1'b1;
      tick();                                   // edge E: byte accepted
      valid = 1'b0;
      check("tbl_level_E", level, 1);
      check("tbl_busy_E", busy, 1);
      check("tbl_tx_E", tx, 1);
      for (int k = 0; k < FC; k++) begin
        tick();                                 // edge E+1+k
        check("tbl_tx", tx, frame_bit(vecs[i].data, vecs[i].exp_par, k / DIV));
        check("tbl_busy", busy, 1);
        if (k == 0) check("tbl_level_pop", level, 0);
      end
      tick();                                   // edge E+FC+1
      check("tbl_busy_fall", busy, 0);
      check("tbl_tx_idle", tx, 1);
      tick(); tick();
    end

    // ---- back-to-back frames ----
    b2[0] = 8'hA3;
    b2[1] = 8'h0F;
    data = b2[0];
    valid = 1'b1;
    tick();
    check("b2b_level0", level, 1);
    data = b2[1];
    tick();
    valid = 1'b0;
    check("b2b_level1", level, 1);
    for (int k = 0; k < 2 * FC; k++) begin
      if (k > 0) tick();
      check("b2b_tx", tx, frame_bit(b2[k / FC], ^b2[k / FC], (k % FC) / DIV));
      if (k == FC) check("b2b_level2", level, 0);
    end
    tick();
    check("b2b_busy_fall", busy, 0);
    tick(); tick();

    // ---- fill a full FIFO while holding valid ----
    accepted = 0;
    valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data = 8'h10 + 8'(i);
      if (DEPTH - fill_q.size() + (i > 0 ? 1 : 0) > 0 && accepted < DEPTH + 1) begin
        fill_q.push_back(data);
        accepted++;
      end
      tick();
    end
    valid = 1'b0;
    check("fill_accepted_model", accepted, 5);
    check("fill_ready_low", ready, 0);
    check("fill_level_full", level, DEPTH);
    for (int p = 6; p < 5 * FC; p++) begin
      check("fill_tx", tx, frame_bit(fill_q[p / FC], ^fill_q[p / FC], (p % FC) / DIV));
      if (p == FC - 1) check("fill_ready_before_pop", ready, 0);
      if (p == FC) check("fill_ready_after_pop", ready, 1);
      tick();
    end
    check("fill_busy_end", busy, 0);
    check("fill_level_end", level, 0);
    check("fill_tx_end", tx, 1);
    tick();

    // ---- reset during data bit 3 of 0xFF with 3 bytes queued ----
    data = 8'hFF; valid = 1'b1; tick();
    data = 8'h01; tick();
    data = 8'h02; tick();
    data = 8'h03; tick();
    valid = 1'b0;
    check("rstmid_level", level, 3);
    repeat (14) tick();
    check("rstmid_bit3", tx, 1);
    check("rstmid_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    check("rstmid_tx", tx, 1);
    check("rstmid_level0", level, 0);
    check("rstmid_busy0", busy, 0);
    check("rstmid_ready0", ready, 0);
    rst = 1'b0;
    tick();
    check("rstmid_ready1", ready, 1);
    for (int k = 0; k < 50; k++) begin
      tick();
      check("rstmid_idle_tx", tx, 1);
      check("rstmid_idle_busy", busy, 0);
    end

    // ---- flush during the frame of 0x41 ----
    data = 8'h41; valid = 1'b1; tick();
    data = 8'h42; tick();
    data = 8'h43; tick();
    valid = 1'b0;
    check("flush_level_pre", level, 2);
    for (int p = 1; p < FC; p++) begin
      check("flush_tx", tx, frame_bit(8'h41, ^8'h41, p / DIV));
      if (p == 8) begin
        flush = 1'b1;
        valid = 1'b1;
        data  = 8'h99;
      end
      tick();
      if (p == 8) begin
        flush = 1'b0;
        valid = 1'b0;
        check("flush_level_post", level, 0);
      end
    end
    check("flush_busy_end", busy, 0);
    check("flush_level_end", level, 0);
    for (int k = 0; k < 50; k++) begin
      tick();
      check("flush_idle_tx", tx, 1);
    end

    // ---- randomized traffic against a frame-timeline model ----
    rst = 1'b1; tick(); rst = 1'b0; tick();
    active = 1'b0;
    pos = 0;
    cur = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ((c / 500) % 2 == 0) valid = ($urandom_range(0, 3) == 0);
      else                    valid = ($urandom_range(0, 59) == 0);
      data  = 8'($urandom);
      mpush = valid && (mq.size() != DEPTH);
      tick();
      pre     = mq.size();
      end_now = active && (pos == FC - 1);
      if ((!active || end_now) && pre > 0) begin
        cur    = mq.pop_front();
        active = 1'b1;
        pos    = 0;
      end else if (end_now) begin
        active = 1'b0;
      end else if (active) begin
        pos++;
      end
      if (mpush) mq.push_back(data);
      check("rnd_tx", tx, active ? frame_bit(cur, ^cur, pos / DIV) : 1);
      check("rnd_level", level, mq.size());
      check("rnd_busy", busy, (active || mq.size() > 0) ? 1 : 0);
      check("rnd_ready", ready, (mq.size() != DEPTH) ? 1 : 0);
    end
    valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
